axi4s2data: RTL and testbench



---
 rtl/axi4s_pkg.sv | 23 ++
 rtl/sync_fifo_fwft.sv | 72 +++++++
 rtl/axi4s2data.sv | 116 +++++++++++
 tb/tb_axi4s2data.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/axi4s_pkg.sv
// rtl/axi4s_pkg.sv - shared AXI4-Stream types, widths and packet-length helper
//
// Shared by the packetising stage and axi4s2data.
//   packet_len : beats per packet for a given byte size and data width
//   axis_beat_t: {last, data} beat as stored in stream buffers
//   COUNT_W    : packet counter width
//   ERR_W      : error counter width
package axi4s_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int COUNT_W    = 32;
    localparam int ERR_W      = 16;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } axis_beat_t;

    function automatic int packet_len(input int packet_byte, input int data_width);
        return packet_byte / (data_width / 8);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through synchronous FIFO
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, wdata  : write request and data (ignored when full)
//   pop          : consume head entry (ignored when empty)
//   rdata        : head entry, zero while empty
//   full, empty  : occupancy flags
//   count        : number of stored entries, one bit wider than the pointers
module sync_fifo_fwft #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Gate the head with empty so stale storage never leaks out after a reset.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the cleared count already marks it empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/axi4s2data.sv
// rtl/axi4s2data.sv - AXI4-Stream slave to data/valid/ready with length checking
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   tdata, tlast, tvalid       : stream input
//   tready                     : backpressure, low while full or before first edge out of reset
//   out_data, out_last         : FIFO head beat
//   out_valid, out_ready       : downstream handshake
//   pkt_count                  : packets closed by tlast (wrapping)
//   err_count                  : length errors (saturating)
//   len_err                    : sticky length-error flag
module axi4s2data
    import axi4s_pkg::*;
#(
    parameter int PACKET_BYTE = 4194304,
    parameter int DATA_WIDTH  = 64,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tdata,
    input  logic                  tlast,
    input  logic                  tvalid,
    output logic                  tready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COUNT_W-1:0]    pkt_count,
    output logic [ERR_W-1:0]      err_count,
    output logic                  len_err
);

    localparam int PACKET_LEN = packet_len(PACKET_BYTE, DATA_WIDTH);
    localparam int BEAT_W     = $clog2(PACKET_LEN) + 1;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    logic                  ready_en_q;
    logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [COUNT_W-1:0]    pkt_count_q, pkt_count_d;
    logic [ERR_W-1:0]      err_count_q, err_count_d;
    logic                  len_err_q, len_err_d;

    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [DATA_WIDTH:0]   fifo_rdata;
    logic                  accept, last_slot, err_evt;

    assign tready    = ready_en_q && !fifo_full;
    assign accept    = tvalid && tready;
    assign out_valid = (fifo_count != '0);
    assign out_data  = fifo_rdata[DATA_WIDTH-1:0];
    assign out_last  = fifo_rdata[DATA_WIDTH];
    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;
    assign len_err   = len_err_q;

    sync_fifo_fwft #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (out_ready && !fifo_empty),
        .wdata ({tlast, tdata}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign last_slot = (beat_cnt_q == BEAT_W'(PACKET_LEN - 1));

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        pkt_count_d = pkt_count_q;
        err_count_d = err_count_q;
        len_err_d   = len_err_q;
        err_evt     = 1'b0;
        if (accept) begin
            if (tlast) begin
                pkt_count_d = pkt_count_q + 1'b1;
                beat_cnt_d  = '0;
                err_evt     = !last_slot;
            end else if (last_slot) begin
                // Missing tlast: restart counting so the next beat opens a packet.
                err_evt    = 1'b1;
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
        if (err_evt) begin
            len_err_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q  <= 1'b0;
            beat_cnt_q  <= '0;
            pkt_count_q <= '0;
            err_count_q <= '0;
            len_err_q   <= 1'b0;
        end else begin
            ready_en_q  <= 1'b1;
            beat_cnt_q  <= beat_cnt_d;
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
            len_err_q   <= len_err_d;
        end
    end

endmodule

// File: tb/tb_axi4s2data.sv
// tb/tb_axi4s2data.sv - scoreboard bench for axi4s2data
module tb_axi4s2data;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] tdata = '0;
    logic        tlast = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [63:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] pkt_count;
    logic [15:0] err_count;
    logic        len_err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        mon_en = 1'b0;
    logic [64:0] exp_q[$];

    axi4s2data #(
        .PACKET_BYTE (32),
        .DATA_WIDTH  (64),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tdata     (tdata),
        .tlast     (tlast),
        .tvalid    (tvalid),
        .tready    (tready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pkt_count (pkt_count),
        .err_count (err_count),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs only change at posedge+1, so at the negedge the handshake seen
    // here is exactly what the DUT will act on at the next rising edge.
    always @(negedge clk) begin
        logic [64:0] e;
        if (mon_en) begin
            check("out_valid_occ", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
            check("tready_occ", {63'd0, tready}, {63'd0, exp_q.size() != DEPTH});
            if (out_valid && out_ready) begin
                check("pop_expected", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[63:0]);
                    check("out_last", {63'd0, out_last}, {63'd0, e[64]});
                end
            end
            if (tvalid && tready) exp_q.push_back({tlast, tdata});
        end
    end

    task automatic send(input logic [63:0] d, input logic l);
        int   n;
        logic ok;
        n = 0;
        ok = 1'b0;
        tdata = d;
        tlast = l;
        tvalid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = tready;
            @(posedge clk);
            #1;
            n++;
        end
        tvalid = 1'b0;
        check("accept", {63'd0, ok}, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        exp_q.delete();
        rst_n = 1'b0;
        tvalid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #3;
        check("rst_tready", {63'd0, tready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_counts", {15'd0, len_err, err_count, pkt_count}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_tready_pre_edge", {63'd0, tready}, 64'd0);
        tvalid = 1'b0;
        @(posedge clk);
        #1;
        check("rel_tready_post_edge", {63'd0, tready}, 64'd1);
        mon_en = 1'b1;
    endtask

    initial begin
        // Streaming with tlast on 4 and 8
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(64'(i), (i % 4) == 0);
        drain();
        check("t2_pkt", 64'(pkt_count), 64'd2);
        check("t2_err", 64'(err_count), 64'd0);
        check("t2_len_err", {63'd0, len_err}, 64'd0);

        // Backpressure: fill with out_ready low, then release
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(64'(i), 1'b0);
        tdata = 64'd5;
        tlast = 1'b0;
        tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_full_tready", {63'd0, tready}, 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(64'd5, 1'b0);
        send(64'd6, 1'b0);
        drain();
        check("t3_err", 64'(err_count), 64'd1);
        check("t3_pkt", 64'(pkt_count), 64'd0);

        // Short packet then a good one
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) send(64'(16 + i), i == 3);
        for (int i = 1; i <= 4; i++) send(64'(32 + i), i == 4);
        drain();
        check("t4_len_err", {63'd0, len_err}, 64'd1);
        check("t4_err", 64'(err_count), 64'd1);
        check("t4_pkt", 64'(pkt_count), 64'd2);

        // Missing tlast: resync at beat 4, beat 8 closes a clean packet
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(64'(48 + i), i == 8);
        drain();
        check("t5_err", 64'(err_count), 64'd1);
        check("t5_pkt", 64'(pkt_count), 64'd1);
        check("t5_len_err", {63'd0, len_err}, 64'd1);

        // Asynchronous reset with two beats buffered mid-packet
        out_ready = 1'b0;
        send(64'hA1, 1'b0);
        send(64'hA2, 1'b0);
        check("t6_pre_valid", {63'd0, out_valid}, 64'd1);
        check("t6_pre_err", 64'(err_count), 64'd1);
        #3;
        mon_en = 1'b0;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("t6_out_valid", {63'd0, out_valid}, 64'd0);
        check("t6_tready", {63'd0, tready}, 64'd0);
        check("t6_out_data", out_data, 64'd0);
        check("t6_pkt", 64'(pkt_count), 64'd0);
        check("t6_err", 64'(err_count), 64'd0);
        check("t6_len_err", {63'd0, len_err}, 64'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Partial-packet state lost: a fresh 4-beat packet is clean
        mon_en = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send(64'(96 + i), i == 4);
        drain();
        check("t7_err", 64'(err_count), 64'd0);
        check("t7_pkt", 64'(pkt_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
